sha2_round_logic: RTL and testbench

Parametrised, pipelined SHA-2 round-logic unit. Computes the message-independent part of one compression round: T2 = Σ0(a) + Maj(a,b,c), and T1p = h + Σ1(e) + Ch(e,f,g). K[t] and W[t] are added downstream. It sits between the working-variable register file and the round adder. It replaces the single-function choice register with a two-stage valid/ready pipeline serving SHA-256 (WIDTH=32) and SHA-512 (WIDTH=64).

---
 rtl/sha2_round_logic.sv | 134 +++++++++++++
 tb/tb_sha2_round_logic.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_round_logic.sv
// Two-stage valid/ready SHA-2 round logic: produces T2 = S0(a)+Maj(a,b,c) and
// the message-independent part of T1 (h + S1(e) + Ch(e,f,g)) for SHA-256/512.
`default_nettype none

module sha2_round_logic #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] t1_partial,
    output logic [WIDTH-1:0] t2
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_width_check
        $error("sha2_round_logic: WIDTH must be 32 or 64");
    end

    localparam int S0_R0 = (WIDTH == 64) ? 28 : 2;
    localparam int S0_R1 = (WIDTH == 64) ? 34 : 13;
    localparam int S0_R2 = (WIDTH == 64) ? 39 : 22;
    localparam int S1_R0 = (WIDTH == 64) ? 14 : 6;
    localparam int S1_R1 = (WIDTH == 64) ? 18 : 11;
    localparam int S1_R2 = (WIDTH == 64) ? 41 : 25;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    function automatic logic [WIDTH-1:0] big_sigma0(input logic [WIDTH-1:0] x);
        return rotr(x, S0_R0) ^ rotr(x, S0_R1) ^ rotr(x, S0_R2);
    endfunction

    function automatic logic [WIDTH-1:0] big_sigma1(input logic [WIDTH-1:0] x);
        return rotr(x, S1_R0) ^ rotr(x, S1_R1) ^ rotr(x, S1_R2);
    endfunction

    function automatic logic [WIDTH-1:0] ch_fn(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [WIDTH-1:0] maj_fn(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    logic             vld_p1;
    logic             vld_p2;
    logic [WIDTH-1:0] sigma0_p1;
    logic [WIDTH-1:0] maj_p1;
    logic [WIDTH-1:0] sigma1_p1;
    logic [WIDTH-1:0] ch_p1;
    logic [WIDTH-1:0] h_p1;
    logic [WIDTH-1:0] t2_p2;
    logic [WIDTH-1:0] t1_partial_p2;

    logic s2_free;
    logic s1_load;
    logic s2_load;

    // in_ready follows out_ready combinationally so a full pipe still streams
    assign s2_free  = !vld_p2 || out_ready;
    assign in_ready = !flush && (!vld_p1 || s2_free);
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = vld_p1 && s2_free && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s2_free) begin
                vld_p2 <= vld_p1;
            end
            if (s1_load) begin
                vld_p1 <= 1'b1;
            end else if (s2_load) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // Stage 1: boolean functions of the working variables
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sigma0_p1 <= '0;
            maj_p1    <= '0;
            sigma1_p1 <= '0;
            ch_p1     <= '0;
            h_p1      <= '0;
        end else if (s1_load) begin
            sigma0_p1 <= big_sigma0(a);
            maj_p1    <= maj_fn(a, b, c);
            sigma1_p1 <= big_sigma1(e);
            ch_p1     <= ch_fn(e, f, g);
            h_p1      <= h;
        end
    end

    // Stage 2: modular sums
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            t2_p2         <= '0;
            t1_partial_p2 <= '0;
        end else if (s2_load) begin
            t2_p2         <= sigma0_p1 + maj_p1;
            t1_partial_p2 <= h_p1 + sigma1_p1 + ch_p1;
        end
    end

    assign out_valid  = vld_p2;
    assign t2         = t2_p2;
    assign t1_partial = t1_partial_p2;

endmodule

`default_nettype wire

// File: tb/tb_sha2_round_logic.sv
// Bench for sha2_round_logic: a 32-bit and a 64-bit instance share one stimulus
// stream and are checked every cycle against a transaction-level queue model.
`timescale 1ns/1ps

module tb_sha2_round_logic;

    typedef struct packed {
        logic [63:0] a, b, c, e, f, g, h;
    } op_t;

    typedef struct packed {
        int unsigned t;
        logic [31:0] t2_32;
        logic [31:0] t1_32;
        logic [63:0] t2_64;
        logic [63:0] t1_64;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    op_t         cur_op;

    logic        in_ready32, out_valid32;
    logic [31:0] t1_32, t2_32;
    logic        in_ready64, out_valid64;
    logic [63:0] t1_64, t2_64;

    int n_err = 0;
    int n_chk = 0;
    int unsigned cyc = 0;
    exp_t q[$];
    bit acc_m = 0;
    bit pop_m = 0;
    int n_acc = 0;
    int n_out = 0;

    always #5 clock = ~clock;

    sha2_round_logic #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .a(cur_op.a[31:0]), .b(cur_op.b[31:0]), .c(cur_op.c[31:0]),
        .e(cur_op.e[31:0]), .f(cur_op.f[31:0]), .g(cur_op.g[31:0]), .h(cur_op.h[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .t1_partial(t1_32), .t2(t2_32)
    );

    sha2_round_logic #(.WIDTH(64)) dut64 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .a(cur_op.a), .b(cur_op.b), .c(cur_op.c),
        .e(cur_op.e), .f(cur_op.f), .g(cur_op.g), .h(cur_op.h),
        .out_valid(out_valid64), .out_ready(out_ready),
        .t1_partial(t1_64), .t2(t2_64)
    );

    function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // Reference results straight from the SHA-2 round definitions
    function automatic exp_t model(input op_t o, input int unsigned t);
        exp_t r;
        logic [31:0] a3, b3, c3, e3, f3, g3, h3;
        a3 = o.a[31:0]; b3 = o.b[31:0]; c3 = o.c[31:0];
        e3 = o.e[31:0]; f3 = o.f[31:0]; g3 = o.g[31:0]; h3 = o.h[31:0];
        r.t = t;
        r.t2_32 = (rr32(a3, 2) ^ rr32(a3, 13) ^ rr32(a3, 22)) + ((a3 & b3) | (a3 & c3) | (b3 & c3));
        r.t1_32 = h3 + (rr32(e3, 6) ^ rr32(e3, 11) ^ rr32(e3, 25)) + ((e3 & f3) | (~e3 & g3));
        r.t2_64 = (rr64(o.a, 28) ^ rr64(o.a, 34) ^ rr64(o.a, 39))
                + ((o.a & o.b) | (o.a & o.c) | (o.b & o.c));
        r.t1_64 = o.h + (rr64(o.e, 14) ^ rr64(o.e, 18) ^ rr64(o.e, 41))
                + ((o.e & o.f) | (~o.e & o.g));
        return r;
    endfunction

    function automatic op_t mk(input logic [63:0] a, b, c, e, f, g, h);
        op_t o;
        o.a = a; o.b = b; o.c = c; o.e = e; o.f = f; o.g = g; o.h = h;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a = {$urandom, $urandom}; o.b = {$urandom, $urandom};
        o.c = {$urandom, $urandom}; o.e = {$urandom, $urandom};
        o.f = {$urandom, $urandom}; o.g = {$urandom, $urandom};
        o.h = {$urandom, $urandom};
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model; handshakes are applied at the edge
    always @(negedge clock) begin
        bit eiv, eov;
        acc_m = 0;
        pop_m = 0;
        if (reset) begin
            eiv = !flush && (q.size() < 2 || out_ready);
            eov = q.size() > 0 && q[0].t < cyc;
            chk("in_ready32", in_ready32, eiv);
            chk("in_ready64", in_ready64, eiv);
            chk("out_valid32", out_valid32, eov);
            chk("out_valid64", out_valid64, eov);
            if (eov) begin
                chk("t2_32", t2_32, q[0].t2_32);
                chk("t1_32", t1_32, q[0].t1_32);
                chk("t2_64", t2_64, q[0].t2_64);
                chk("t1_64", t1_64, q[0].t1_64);
            end
            acc_m = in_valid && eiv;
            pop_m = eov && out_ready;
            if (in_valid && in_ready32) n_acc++;
            if (out_valid32 && out_ready) n_out++;
        end
    end

    always @(posedge clock) begin
        cyc++;
        if (!reset || flush) begin
            q.delete();
        end else begin
            if (pop_m) void'(q.pop_front());
            if (acc_m) q.push_back(model(cur_op, cyc));
        end
    end

    task automatic send(input op_t o);
        bit acc;
        acc = 0;
        cur_op = o;
        in_valid = 1;
        for (int i = 0; i < 30 && !acc; i++) begin
            @(negedge clock);
            acc = in_ready32;
            @(posedge clock);
            #1;
        end
        chk("send_timeout", acc, 1);
    endtask

    task automatic wait_out(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid32;
        end
        chk({name, "_timeout"}, seen, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t op_abc, op_rot, op_ones, op_two, op_p3;
        int base_acc, base_out;
        op_abc  = mk(64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'h510e527f,
                     64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19);
        op_rot  = mk(64'h1, 0, 0, 64'h1, 0, 0, 0);
        op_ones = mk('1, '1, '1, '1, '1, '1, '1);
        op_two  = mk(64'h2, 0, 0, 64'h2, 0, 0, 0);
        op_p3   = mk(64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f0f0f0f0f0f0f0f,
                     64'h8000000000000001, 64'h5555555555555555, 64'haaaaaaaaaaaaaaaa,
                     64'hdeadbeefcafef00d);

        reset = 0; flush = 0; in_valid = 0; out_ready = 0; cur_op = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid32", out_valid32, 0);
        chk("rst_t2_32", t2_32, 0);
        chk("rst_t1_32", t1_32, 0);
        chk("rst_out_valid64", out_valid64, 0);
        chk("rst_t2_64", t2_64, 0);
        chk("rst_t1_64", t1_64, 0);
        @(negedge clock);
        #1 reset = 1;
        #1 chk("rst_in_ready", in_ready32, 1);
        @(posedge clock);
        #1;

        // FIPS 180-4 "abc" round 0
        out_ready = 1;
        send(op_abc);
        in_valid = 0;
        wait_out("abc");
        chk("abc_t2", t2_32, 32'h08909ae5);
        chk("abc_t1", t1_32, 32'hb0edbdd0);
        @(posedge clock); #1;

        send(op_rot);
        in_valid = 0;
        wait_out("rot");
        chk("rot_t2", t2_32, 32'h40080400);
        chk("rot_t1", t1_32, 32'h04200080);
        @(posedge clock); #1;

        send(op_ones);
        in_valid = 0;
        wait_out("wrap");
        chk("wrap_t2_32", t2_32, 32'hfffffffe);
        chk("wrap_t1_32", t1_32, 32'hfffffffd);
        chk("wrap_t2_64", t2_64, 64'hfffffffffffffffe);
        chk("wrap_t1_64", t1_64, 64'hfffffffffffffffd);
        @(posedge clock); #1;

        // Backpressure: two buffered, third held off, then drain one per cycle
        out_ready = 0;
        send(op_rot);
        send(op_ones);
        cur_op = op_abc;
        in_valid = 1;
        repeat (3) begin
            @(negedge clock);
            chk("bp_in_ready", in_ready32, 0);
            chk("bp_out_valid", out_valid32, 1);
            chk("bp_hold_t2", t2_32, 32'h40080400);
            chk("bp_hold_t1", t1_32, 32'h04200080);
            @(posedge clock); #1;
        end
        out_ready = 1;
        @(negedge clock);
        chk("bp_first", t2_32, 32'h40080400);
        @(posedge clock); #1;
        cur_op = op_p3;
        @(negedge clock);
        chk("bp_second_v", out_valid32, 1);
        chk("bp_second", t2_32, 32'hfffffffe);
        @(posedge clock); #1;
        in_valid = 0;
        @(negedge clock);
        chk("bp_third_v", out_valid32, 1);
        chk("bp_third", t2_32, 32'h08909ae5);
        repeat (4) @(posedge clock);
        #1;

        // Flush with two results in flight
        out_ready = 0;
        send(op_rot);
        send(op_abc);
        cur_op = op_ones;
        in_valid = 1;
        flush = 1;
        @(negedge clock);
        chk("flush_in_ready", in_ready32, 0);
        @(posedge clock); #1;
        flush = 0;
        in_valid = 0;
        @(negedge clock);
        chk("flush_out_valid", out_valid32, 0);
        chk("flush_in_ready_after", in_ready32, 1);
        @(posedge clock); #1;
        out_ready = 1;
        send(op_two);
        in_valid = 0;
        wait_out("post_flush");
        chk("post_flush_t2", t2_32, 32'h80100800);
        chk("post_flush_t1", t1_32, 32'h08400100);
        repeat (3) @(posedge clock);
        #1;

        // Asynchronous reset mid-stream
        out_ready = 0;
        send(op_abc);
        send(op_ones);
        in_valid = 0;
        @(negedge clock);
        #1 reset = 0;
        #1;
        chk("mid_rst_out_valid32", out_valid32, 0);
        chk("mid_rst_t2_32", t2_32, 0);
        chk("mid_rst_t1_32", t1_32, 0);
        chk("mid_rst_out_valid64", out_valid64, 0);
        chk("mid_rst_t2_64", t2_64, 0);
        chk("mid_rst_t1_64", t1_64, 0);
        @(posedge clock);
        @(negedge clock);
        #1 reset = 1;
        @(posedge clock); #1;

        // Random streaming with random backpressure
        base_acc = n_acc;
        base_out = n_out;
        for (int i = 0; i < 400; i++) begin
            bit acc;
            @(negedge clock);
            acc = in_valid && in_ready32;
            @(posedge clock); #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(3) != 0);
                cur_op = rand_op();
            end
            out_ready = ($urandom_range(2) != 0);
        end
        @(negedge clock);
        while (in_valid && !in_ready32) begin
            @(posedge clock); #1;
            out_ready = 1;
            @(negedge clock);
        end
        @(posedge clock); #1;
        in_valid = 0;
        out_ready = 1;
        repeat (6) @(posedge clock);
        #1;
        chk("random_count", n_out - base_out, n_acc - base_acc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
